// File: rtl/alu32.sv
// 32-bit add/sub/and/or ALU with NZCV flags and a clocked flag register.
// Build macro ALU_FLAGS_EN compiles in the flags; otherwise they read zero.
module alu32 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  ALUControl,
    input  logic        flags_we,
    output logic [31:0] y,
    output logic [3:0]  ALUFlags,
    output logic [3:0]  flags_q
);

    logic [31:0] b_eff;
    logic [32:0] sum;

    // Subtract reuses the adder: a + ~b + 1.
    assign b_eff = ALUControl[0] ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_eff} + {32'b0, ALUControl[0]};

    always_comb begin
        y = 32'h0;
        unique case (ALUControl)
            2'b00:   y = sum[31:0];
            2'b01:   y = sum[31:0];
            2'b10:   y = a & b;
            2'b11:   y = a | b;
            default: y = 32'h0;
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic       arith;
    logic       n_flag;
    logic       z_flag;
    logic       c_flag;
    logic       v_flag;
    logic [3:0] flags_d;

    assign arith  = ~ALUControl[1];
    assign n_flag = y[31];
    assign z_flag = (y == 32'h0);
    assign c_flag = arith & sum[32];
    assign v_flag = arith & (a[31] == b_eff[31]) & (sum[31] != a[31]);

    assign ALUFlags = {n_flag, z_flag, c_flag, v_flag};

    always_comb begin
        flags_d = flags_q;
        if (flags_we) flags_d = ALUFlags;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) flags_q <= 4'b0000;
        else          flags_q <= flags_d;
    end
`else
    logic unused_sig;

    assign ALUFlags   = 4'b0000;
    assign flags_q    = 4'b0000;
    assign unused_sig = ^{clk, reset_n, flags_we, sum[32]};
`endif

endmodule

// File: tb/tb_alu32.sv
// Self-checking bench for alu32: directed vectors, flag register, random sweep.
// Flag expectations collapse to zero when ALU_FLAGS_EN is not defined.
module tb_alu32;

    logic        clk;
    logic        reset_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  ALUControl;
    logic        flags_we;
    logic [31:0] y;
    logic [3:0]  ALUFlags;
    logic [3:0]  flags_q;

    int checks = 0;
    int errors = 0;

    alu32 dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a         (a),
        .b         (b),
        .ALUControl(ALUControl),
        .flags_we  (flags_we),
        .y         (y),
        .ALUFlags  (ALUFlags),
        .flags_q   (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] fexp(input logic [3:0] f);
`ifdef ALU_FLAGS_EN
        return f;
`else
        return 4'b0000;
`endif
    endfunction

    // Independent reference: wide add, unsigned compare for borrow.
    task automatic model(input logic [31:0] ma, input logic [31:0] mb,
                         input logic [1:0] mc, output logic [31:0] my,
                         output logic [3:0] mf);
        logic [63:0] wide;
        logic        c;
        logic        v;
        c = 1'b0;
        v = 1'b0;
        case (mc)
            2'b00: begin
                wide = {32'b0, ma} + {32'b0, mb};
                my   = wide[31:0];
                c    = wide[32];
                v    = (ma[31] == mb[31]) && (my[31] != ma[31]);
            end
            2'b01: begin
                my = ma - mb;
                c  = (ma >= mb);
                v  = (ma[31] != mb[31]) && (my[31] != ma[31]);
            end
            2'b10:   my = ma & mb;
            default: my = ma | mb;
        endcase
        mf = {my[31], (my == 32'h0), c, v};
    endtask

    task automatic vec(input string tag, input logic [31:0] va,
                       input logic [31:0] vb, input logic [1:0] vc,
                       input logic [31:0] ey, input logic [3:0] ef);
        a          = va;
        b          = vb;
        ALUControl = vc;
        #1;
        chk({tag, "_y"}, y, ey);
        chk({tag, "_f"}, {28'b0, ALUFlags}, {28'b0, fexp(ef)});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] ry;
        logic [3:0]  rf;

        reset_n    = 1'b0;
        flags_we   = 1'b0;
        a          = 32'h0;
        b          = 32'h0;
        ALUControl = 2'b00;

        vec("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 2'b00,
            32'h0000_0000, 4'b0110);
        vec("sub_neg", 32'h0000_0000, 32'h0000_0001, 2'b01,
            32'hFFFF_FFFF, 4'b1000);
        vec("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 2'b00,
            32'h8000_0000, 4'b1001);
        vec("and", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'b10,
            32'h00F0_00F0, 4'b0000);
        vec("or", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'b11,
            32'hFFF0_FFF0, 4'b1000);
        vec("sub_eq", 32'h1234_5678, 32'h1234_5678, 2'b01,
            32'h0000_0000, 4'b0110);
        vec("sub_ovf", 32'h8000_0000, 32'h0000_0001, 2'b01,
            32'h7FFF_FFFF, 4'b0011);
        vec("add_nov", 32'h8000_0000, 32'h8000_0000, 2'b00,
            32'h0000_0000, 4'b0111);
        vec("and_zero", 32'hAAAA_AAAA, 32'h5555_5555, 2'b10,
            32'h0000_0000, 4'b0100);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold", {28'b0, flags_q}, 32'h0);

        @(negedge clk);
        reset_n    = 1'b1;
        a          = 32'hFFFF_FFFF;
        b          = 32'h0000_0001;
        ALUControl = 2'b00;
        flags_we   = 1'b1;
        @(posedge clk);
        #1;
        chk("load1", {28'b0, flags_q}, {28'b0, fexp(4'b0110)});

        flags_we   = 1'b0;
        a          = 32'h7FFF_FFFF;
        b          = 32'h0000_0001;
        @(posedge clk);
        #1;
        chk("hold", {28'b0, flags_q}, {28'b0, fexp(4'b0110)});

        flags_we   = 1'b1;
        a          = 32'h0000_0000;
        ALUControl = 2'b01;
        @(posedge clk);
        #1;
        chk("load2", {28'b0, flags_q}, {28'b0, fexp(4'b1000)});

        flags_we = 1'b0;
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_async", {28'b0, flags_q}, 32'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_lost", {28'b0, flags_q}, 32'h0);

        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            a          = pick();
            b          = pick();
            ALUControl = 2'($urandom_range(0, 3));
            #2;
            model(a, b, ALUControl, ry, rf);
            chk("rnd_y", y, ry);
            chk("rnd_f", {28'b0, ALUFlags}, {28'b0, fexp(rf)});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
